// File: rtl/zapper_reader.sv
// Zapper light-gun reader for the Duck Hunt display path.
//
// The raw trigger is synchronised and debounced. A clean press arms a shot. The shot then
// sequences one dark frame and one target frame, each aligned to frame_start. During those
// frames it samples the synchronised photodiode on visible pixels. It then reports a single
// hit or miss.
//
// Ports:
//   clk          in   pixel clock, all state on posedge
//   reset        in   asynchronous active-high reset
//   valid        in   VGA visible-region flag; light only sampled while high
//   frame_start  in   one-clock pulse at the start of each frame
//   trigger_in   in   raw bouncy trigger, 1 = pressed
//   light_in     in   raw photodiode, 1 = light seen
//   dark_frame   out  high for the whole dark frame
//   target_frame out  high for the whole target frame
//   busy         out  high whenever a shot is in progress
//   hit          out  one-clock pulse when a shot scores
//   miss         out  one-clock pulse when a shot misses
//   shot_count   out  completed shots since reset, wraps at 256
module zapper_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned LIGHT_MIN       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic       frame_start,
    input  logic       trigger_in,
    input  logic       light_in,
    output logic       dark_frame,
    output logic       target_frame,
    output logic       busy,
    output logic       hit,
    output logic       miss,
    output logic [7:0] shot_count
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LcW = $clog2(LIGHT_MIN + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LcW-1:0] LcMax  = LcW'(LIGHT_MIN);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StDark,
        StTarget,
        StReport
    } state_e;

    state_e state_q, state_d;

    logic           trig_s1_q, trig_s2_q;
    logic           light_s1_q, light_s2_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           db_lvl_q, db_lvl_d;
    logic           db_prev_q;
    logic           dark_seen_q, dark_seen_d;
    logic [LcW-1:0] light_cnt_q, light_cnt_d;

    logic press_edge;
    logic sample;
    logic score;

    // Two-flop synchronisers for both asynchronous inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_s1_q  <= 1'b0;
            trig_s2_q  <= 1'b0;
            light_s1_q <= 1'b0;
            light_s2_q <= 1'b0;
        end else begin
            trig_s1_q  <= trigger_in;
            trig_s2_q  <= trig_s1_q;
            light_s1_q <= light_in;
            light_s2_q <= light_s1_q;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        if (trig_s2_q == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            db_cnt_d = '0;
            db_lvl_d = ~db_lvl_q;
        end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
    end

    // db_prev_q resets to 0, so a button held through reset still produces one edge.
    assign press_edge = db_lvl_q & ~db_prev_q;
    assign sample     = valid & light_s2_q;

    always_comb begin
        state_d     = state_q;
        dark_seen_d = dark_seen_q;
        light_cnt_d = light_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (press_edge) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (frame_start) begin
                    state_d     = StDark;
                    dark_seen_d = 1'b0;
                    light_cnt_d = '0;
                end
            end
            StDark: begin
                if (sample) begin
                    dark_seen_d = 1'b1;
                end
                if (frame_start) begin
                    state_d = StTarget;
                end
            end
            StTarget: begin
                if (sample && (light_cnt_q != LcMax)) begin
                    light_cnt_d = light_cnt_q + LcW'(1);
                end
                if (frame_start) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Uses next-state values so that a sample taken on the final frame_start clock still counts.
    assign score = ~dark_seen_d && (light_cnt_d == LcMax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            db_lvl_q    <= 1'b0;
            db_prev_q   <= 1'b0;
            dark_seen_q <= 1'b0;
            light_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            db_lvl_q    <= db_lvl_d;
            db_prev_q   <= db_lvl_q;
            dark_seen_q <= dark_seen_d;
            light_cnt_q <= light_cnt_d;
        end
    end

    // Outputs are registered copies of the next-state decode, so they track state_q exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dark_frame   <= 1'b0;
            target_frame <= 1'b0;
            busy         <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            shot_count   <= 8'd0;
        end else begin
            dark_frame   <= (state_d == StDark);
            target_frame <= (state_d == StTarget);
            busy         <= (state_d != StIdle);
            hit          <= (state_d == StReport) && score;
            miss         <= (state_d == StReport) && !score;
            if (state_d == StReport) begin
                shot_count <= shot_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_zapper_reader.sv
// Directed testbench for zapper_reader. It uses DEBOUNCE_CYCLES=4, LIGHT_MIN=3 and short frames.
module tb_zapper_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       trigger_in = 1'b0;
    logic       light_in = 1'b0;
    logic       dark_frame;
    logic       target_frame;
    logic       busy;
    logic       hit;
    logic       miss;
    logic [7:0] shot_count;

    int n_checks = 0;
    int n_errors = 0;

    // Free-running event counters, sampled on the falling edge.
    int hit_n = 0;
    int miss_n = 0;
    int both_n = 0;
    int dark_n = 0;
    int tgt_n = 0;
    int busy_n = 0;

    int h0, m0, d0, t0, b0, bz0;

    zapper_reader #(
        .DEBOUNCE_CYCLES(4),
        .LIGHT_MIN      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .frame_start (frame_start),
        .trigger_in  (trigger_in),
        .light_in    (light_in),
        .dark_frame  (dark_frame),
        .target_frame(target_frame),
        .busy        (busy),
        .hit         (hit),
        .miss        (miss),
        .shot_count  (shot_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        hit_n  <= hit_n + int'(hit);
        miss_n <= miss_n + int'(miss);
        both_n <= both_n + int'(hit & miss);
        dark_n <= dark_n + int'(dark_frame);
        tgt_n  <= tgt_n + int'(target_frame);
        busy_n <= busy_n + int'(busy);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        h0  = hit_n;
        m0  = miss_n;
        d0  = dark_n;
        t0  = tgt_n;
        b0  = both_n;
        bz0 = busy_n;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        valid       = 1'b0;
        frame_start = 1'b0;
        trigger_in  = 1'b0;
        light_in    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // Press, wait (bounded) for the shot to arm, then let go of the trigger.
    task automatic do_press(input string tag);
        trigger_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy) break;
        end
        check(tag, 32'(busy), 32'd1);
        trigger_in = 1'b0;
    endtask

    // One frame of len clocks: frame_start on the first clock, light held at lvl except the
    // last three clocks, valid high for nv clocks starting at clock 5.
    task automatic frame(input logic lvl, input int nv, input int trig_cyc, input int len);
        for (int c = 0; c < len; c++) begin
            frame_start = (c == 0);
            light_in    = (c < len - 3) ? lvl : 1'b0;
            valid       = (c >= 5) && (c < 5 + nv);
            if (c == trig_cyc) trigger_in = 1'b1;
            tick();
        end
        frame_start = 1'b0;
        valid       = 1'b0;
        light_in    = 1'b0;
    endtask

    // The frame_start that ends the target frame, then the REPORT clock.
    task automatic do_report();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic do_shot(input logic dl, input int dnv, input logic tl, input int tnv,
                           input int len);
        do_press("arm");
        frame(dl, dnv, -1, len);
        frame(tl, tnv, -1, len);
        do_report();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_dark", 32'(dark_frame), 32'd0);
        check("rst_target", 32'(target_frame), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_count", 32'(shot_count), 32'd0);
        apply_reset();

        // 1: a two-clock bounce never arms
        snap();
        trigger_in = 1'b1;
        repeat (2) tick();
        trigger_in = 1'b0;
        repeat (20) tick();
        check("bounce_busy", 32'(busy_n - bz0), 32'd0);
        check("bounce_count", 32'(shot_count), 32'd0);

        // 2: light only on three visible target clocks -> hit
        apply_reset();
        snap();
        do_shot(1'b0, 5, 1'b1, 3, 40);
        check("t2_hit", 32'(hit_n - h0), 32'd1);
        check("t2_miss", 32'(miss_n - m0), 32'd0);
        check("t2_dark_len", 32'(dark_n - d0), 32'd40);
        check("t2_tgt_len", 32'(tgt_n - t0), 32'd40);
        check("t2_count", 32'(shot_count), 32'd1);
        check("t2_busy_end", 32'(busy), 32'd0);

        // 3: light in the dark frame -> miss even with plenty of target light
        apply_reset();
        snap();
        do_shot(1'b1, 1, 1'b1, 10, 40);
        check("t3_miss", 32'(miss_n - m0), 32'd1);
        check("t3_hit", 32'(hit_n - h0), 32'd0);
        check("t3_count", 32'(shot_count), 32'd1);

        // 4: two visible samples plus long invisible light -> miss
        apply_reset();
        snap();
        do_shot(1'b0, 5, 1'b1, 2, 40);
        check("t4_miss", 32'(miss_n - m0), 32'd1);
        check("t4_hit", 32'(hit_n - h0), 32'd0);

        // 5: press during TARGET is discarded; release and re-press starts a new shot
        apply_reset();
        snap();
        do_press("t5_arm");
        frame(1'b0, 5, -1, 40);
        frame(1'b1, 3, 2, 40);
        do_report();
        snap();
        repeat (20) tick();
        check("t5_no_rearm", 32'(busy_n - bz0), 32'd0);
        check("t5_one_report", 32'(hit_n - h0 + miss_n - m0), 32'd0);
        trigger_in = 1'b0;
        repeat (10) tick();
        do_shot(1'b0, 0, 1'b1, 4, 40);
        check("t5_hit2", 32'(hit_n - h0), 32'd1);
        check("t5_count", 32'(shot_count), 32'd2);

        // 6: asynchronous reset in DARK aborts with no pulse and clears the count
        apply_reset();
        do_shot(1'b0, 0, 1'b0, 0, 20);
        check("t6_count_pre", 32'(shot_count), 32'd1);
        do_press("t6_arm");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
        check("t6_in_dark", 32'(dark_frame), 32'd1);
        snap();
        #2 reset = 1'b1;
        #1;
        check("t6_dark", 32'(dark_frame), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_count", 32'(shot_count), 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("t6_no_pulse", 32'(hit_n - h0 + miss_n - m0), 32'd0);

        // Counter wrap: 255 shots, then one more returns to 0
        apply_reset();
        for (int s = 0; s < 255; s++) do_shot(1'b0, 0, 1'b0, 0, 8);
        check("wrap_255", 32'(shot_count), 32'd255);
        do_shot(1'b0, 0, 1'b0, 0, 8);
        check("wrap_0", 32'(shot_count), 32'd0);
        check("never_both", 32'(both_n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
